// File: rtl/hazard_control_unit_if.sv
// Hazard-control bundle between the ID-stage pipeline logic and the hazard
// control unit.
//   master : pipeline side; drives decode/stage info and consumes the
//            forwarding selects and stall/flush/handshake controls.
//   slave  : hazard control unit.
interface hazard_control_unit_if #(
    parameter int FWD_STAGES = 2,
    parameter int SEL_W      = $clog2(FWD_STAGES + 1)
);
    logic [4:0]              drs1, drs2;
    logic                    duseRs1, duseRs2;
    logic                    dIsMulDiv;
    logic [5*FWD_STAGES-1:0] stgRd;
    logic [FWD_STAGES-1:0]   stgWreg;
    logic                    eIsLoad;
    logic                    brTaken;
    logic                    mdDone;
    logic [SEL_W-1:0]        qaSel, qbSel;
    logic                    pcStall, ifidStall, idexBubble, exStall, ifidFlush;
    logic                    mdStart, mdError;
    logic [15:0]             stallCycles;

    modport master (
        output drs1, drs2, duseRs1, duseRs2, dIsMulDiv, stgRd, stgWreg,
               eIsLoad, brTaken, mdDone,
        input  qaSel, qbSel, pcStall, ifidStall, idexBubble, exStall,
               ifidFlush, mdStart, mdError, stallCycles
    );

    modport slave (
        input  drs1, drs2, duseRs1, duseRs2, dIsMulDiv, stgRd, stgWreg,
               eIsLoad, brTaken, mdDone,
        output qaSel, qbSel, pcStall, ifidStall, idexBubble, exStall,
               ifidFlush, mdStart, mdError, stallCycles
    );
endinterface

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller sitting beside the ID-stage decoder.
// Produces forwarding selects, load-use stalls, branch flushes, and runs a
// start/done handshake (with timeout) to a multi-cycle mul/div unit.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   hz         : hazard_control_unit_if.slave (decode/stage inputs,
//                forwarding selects, stall/flush/mdStart/mdError,
//                16-bit saturating stall-cycle counter)
module hazard_control_unit #(
    parameter int FWD_STAGES        = 2,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int FLUSH_CYCLES      = 1,
    parameter int MD_TIMEOUT        = 64,
    parameter int SEL_W             = $clog2(FWD_STAGES + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    hazard_control_unit_if.slave hz
);
    localparam int CNT_MAX = (LOAD_STALL_CYCLES > FLUSH_CYCLES) ? LOAD_STALL_CYCLES : FLUSH_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
    localparam int TCNT_W  = $clog2(MD_TIMEOUT);

    typedef enum logic [1:0] {RUN, LSTALL, FLUSH, MDWAIT} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TCNT_W-1:0] tcnt_q, tcnt_d;
    logic              err_q, err_d;
    logic [15:0]       scnt_q, scnt_d;

    logic pc_stall, ifid_stall, idex_bubble, ex_stall, ifid_flush, md_start;
    logic lu;

    // Smallest matching stage wins: scan from the far stage down so the
    // nearest match overwrites.
    function automatic logic [SEL_W-1:0] fwd_sel(
        input logic [4:0]              rs,
        input logic                    use_rs,
        input logic [5*FWD_STAGES-1:0] stg_rd,
        input logic [FWD_STAGES-1:0]   stg_wreg
    );
        logic [SEL_W-1:0] sel;
        sel = '0;
        for (int k = FWD_STAGES; k >= 1; k--) begin
            if (use_rs && rs != 5'd0 && stg_wreg[k-1] && stg_rd[5*k-1 -: 5] == rs)
                sel = SEL_W'(k);
        end
        return sel;
    endfunction

    assign hz.qaSel = fwd_sel(hz.drs1, hz.duseRs1, hz.stgRd, hz.stgWreg);
    assign hz.qbSel = fwd_sel(hz.drs2, hz.duseRs2, hz.stgRd, hz.stgWreg);

    // Load in EXE writing a register the ID instruction actually reads.
    assign lu = hz.eIsLoad && hz.stgWreg[0] && hz.stgRd[4:0] != 5'd0 &&
                ((hz.duseRs1 && hz.stgRd[4:0] == hz.drs1) ||
                 (hz.duseRs2 && hz.stgRd[4:0] == hz.drs2));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tcnt_d      = tcnt_q;
        err_d       = err_q;
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        idex_bubble = 1'b0;
        ex_stall    = 1'b0;
        ifid_flush  = 1'b0;
        md_start    = 1'b0;
        case (state_q)
            RUN: begin
                if (hz.brTaken) begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d = FLUSH;
                        cnt_d   = CNT_W'(FLUSH_CYCLES - 2);
                    end
                end else if (lu) begin
                    pc_stall    = 1'b1;
                    ifid_stall  = 1'b1;
                    idex_bubble = 1'b1;
                    if (LOAD_STALL_CYCLES > 1) begin
                        state_d = LSTALL;
                        cnt_d   = CNT_W'(LOAD_STALL_CYCLES - 2);
                    end
                end else if (hz.dIsMulDiv) begin
                    md_start = 1'b1;
                    state_d  = MDWAIT;
                    tcnt_d   = '0;
                end
            end
            LSTALL: begin
                pc_stall    = 1'b1;
                ifid_stall  = 1'b1;
                idex_bubble = 1'b1;
                if (cnt_q == '0) state_d = RUN;
                else             cnt_d   = cnt_q - 1'b1;
            end
            FLUSH: begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                if (cnt_q == '0) state_d = RUN;
                else             cnt_d   = cnt_q - 1'b1;
            end
            MDWAIT: begin
                // Done releases the pipe in the same cycle; a timeout keeps
                // the stall for its final cycle and releases on the next.
                if (hz.mdDone) begin
                    state_d = RUN;
                end else begin
                    pc_stall   = 1'b1;
                    ifid_stall = 1'b1;
                    ex_stall   = 1'b1;
                    if (tcnt_q == TCNT_W'(MD_TIMEOUT - 1)) begin
                        err_d   = 1'b1;
                        state_d = RUN;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
            end
            default: state_d = RUN;
        endcase
        scnt_d = (pc_stall && scnt_q != 16'hFFFF) ? scnt_q + 16'd1 : scnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
            tcnt_q  <= '0;
            err_q   <= 1'b0;
            scnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tcnt_q  <= tcnt_d;
            err_q   <= err_d;
            scnt_q  <= scnt_d;
        end
    end

    // RUN decodes inputs directly, so gate with reset to keep controls quiet.
    assign hz.pcStall     = pc_stall    & rst_n;
    assign hz.ifidStall   = ifid_stall  & rst_n;
    assign hz.idexBubble  = idex_bubble & rst_n;
    assign hz.exStall     = ex_stall    & rst_n;
    assign hz.ifidFlush   = ifid_flush  & rst_n;
    assign hz.mdStart     = md_start    & rst_n;
    assign hz.mdError     = err_q;
    assign hz.stallCycles = scnt_q;
endmodule

// File: tb/tb_hazard_control_unit.sv
module tb_hazard_control_unit;
    localparam int FWD   = 3;
    localparam int LOADC = 3;
    localparam int FLSHC = 2;
    localparam int MDTO  = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_control_unit_if #(.FWD_STAGES(FWD)) hz ();

    hazard_control_unit #(
        .FWD_STAGES(FWD), .LOAD_STALL_CYCLES(LOADC),
        .FLUSH_CYCLES(FLSHC), .MD_TIMEOUT(MDTO)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .hz(hz)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // stimulus variables
    logic [4:0] rd [FWD];
    logic [FWD-1:0] wr;
    logic [4:0] drs1, drs2;
    logic use1, use2, ld, br, mul, done;

    // reference model: remaining work per activity, not a state encoding
    int m_lst, m_fl, m_el, m_cnt;
    bit m_busy, m_err;

    // observed outputs of the last step
    int o_qa, o_qb, o_sc;
    bit o_pc, o_ifs, o_bub, o_ex, o_fl, o_st, o_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic clr();
        for (int k = 0; k < FWD; k++) rd[k] = 5'd0;
        wr = '0; drs1 = 0; drs2 = 0; use1 = 0; use2 = 0;
        ld = 0; br = 0; mul = 0; done = 0;
    endtask

    task automatic model_reset();
        m_lst = 0; m_fl = 0; m_el = 0; m_cnt = 0; m_busy = 0; m_err = 0;
    endtask

    function automatic int fwd_ref(input logic [4:0] rs, input logic u);
        if (!u || rs == 0) return 0;
        for (int k = 1; k <= FWD; k++)
            if (wr[k-1] && rd[k-1] == rs) return k;
        return 0;
    endfunction

    task automatic step();
        bit e_pc, e_ifs, e_bub, e_ex, e_fl, e_st, lu;
        int n_lst, n_fl, n_el;
        bit n_busy, n_err;
        for (int k = 0; k < FWD; k++) hz.stgRd[5*k +: 5] = rd[k];
        hz.stgWreg = wr; hz.drs1 = drs1; hz.drs2 = drs2;
        hz.duseRs1 = use1; hz.duseRs2 = use2; hz.eIsLoad = ld;
        hz.brTaken = br; hz.dIsMulDiv = mul; hz.mdDone = done;
        @(negedge clk);
        {e_pc, e_ifs, e_bub, e_ex, e_fl, e_st} = '0;
        n_lst = m_lst; n_fl = m_fl; n_el = m_el; n_busy = m_busy; n_err = m_err;
        lu = ld && wr[0] && rd[0] != 0 && ((use1 && rd[0] == drs1) || (use2 && rd[0] == drs2));
        if (m_lst > 0) begin
            e_pc = 1; e_ifs = 1; e_bub = 1; n_lst = m_lst - 1;
        end else if (m_fl > 0) begin
            e_fl = 1; e_bub = 1; n_fl = m_fl - 1;
        end else if (m_busy) begin
            if (done) n_busy = 0;
            else begin
                e_pc = 1; e_ifs = 1; e_ex = 1; n_el = m_el + 1;
                if (n_el == MDTO) begin n_err = 1; n_busy = 0; end
            end
        end else if (br) begin
            e_fl = 1; e_bub = 1; n_fl = FLSHC - 1;
        end else if (lu) begin
            e_pc = 1; e_ifs = 1; e_bub = 1; n_lst = LOADC - 1;
        end else if (mul) begin
            e_st = 1; n_busy = 1; n_el = 0;
        end
        o_qa = int'(hz.qaSel); o_qb = int'(hz.qbSel); o_sc = int'(hz.stallCycles);
        o_pc = hz.pcStall; o_ifs = hz.ifidStall; o_bub = hz.idexBubble;
        o_ex = hz.exStall; o_fl = hz.ifidFlush; o_st = hz.mdStart; o_err = hz.mdError;
        chk("qaSel", o_qa, fwd_ref(drs1, use1));
        chk("qbSel", o_qb, fwd_ref(drs2, use2));
        chk("pcStall", o_pc, e_pc);
        chk("ifidStall", o_ifs, e_ifs);
        chk("idexBubble", o_bub, e_bub);
        chk("exStall", o_ex, e_ex);
        chk("ifidFlush", o_fl, e_fl);
        chk("mdStart", o_st, e_st);
        chk("mdError", o_err, m_err);
        chk("stallCycles", o_sc, m_cnt);
        @(posedge clk); #1;
        m_lst = n_lst; m_fl = n_fl; m_el = n_el; m_busy = n_busy; m_err = n_err;
        if (e_pc && m_cnt < 65535) m_cnt++;
    endtask

    initial begin
        int npc, nex;
        model_reset();
        clr();
        // outputs quiet in reset even with hazards on the inputs
        br = 1; mul = 1; ld = 1; rd[0] = 3; wr = 3'b001; drs1 = 3; use1 = 1;
        hz.brTaken = 1; hz.dIsMulDiv = 1; hz.eIsLoad = 1; hz.stgWreg = wr;
        hz.stgRd = '0; hz.stgRd[4:0] = 5'd3; hz.drs1 = 5'd3; hz.duseRs1 = 1;
        hz.drs2 = 0; hz.duseRs2 = 0; hz.mdDone = 0;
        #7;
        chk("rst_pcStall", hz.pcStall, 0);
        chk("rst_ifidFlush", hz.ifidFlush, 0);
        chk("rst_mdStart", hz.mdStart, 0);
        chk("rst_stallCycles", hz.stallCycles, 0);
        chk("rst_mdError", hz.mdError, 0);
        clr();
        @(posedge clk); #1; rst_n = 1;

        // forwarding priority
        drs1 = 5; use1 = 1; drs2 = 5; use2 = 0;
        rd[0] = 5; rd[1] = 5; wr = 3'b011;
        step(); chk("fwd_prio", o_qa, 1); chk("fwd_unused_rs2", o_qb, 0);
        drs1 = 0; step(); chk("fwd_x0", o_qa, 0);
        drs1 = 5; wr = 3'b010; use2 = 1; rd[2] = 5; step();
        chk("fwd_stage2", o_qa, 2); chk("fwd_rs2_stage2", o_qb, 2);

        // load-use stall of exactly LOADC cycles
        clr(); ld = 1; rd[0] = 7; wr = 3'b001; drs2 = 7; use2 = 1;
        npc = 0;
        step(); npc += o_pc;
        clr();
        for (int i = 0; i < 4; i++) begin step(); npc += o_pc; end
        chk("lu_len", npc, LOADC);
        chk("lu_stallcnt", o_sc, 3);

        // branch beats load-use and mul/div
        clr(); br = 1; ld = 1; rd[0] = 7; wr = 3'b001; drs1 = 7; use1 = 1; mul = 1;
        step();
        chk("simul_flush", o_fl, 1); chk("simul_bubble", o_bub, 1);
        chk("simul_nostall", o_pc, 0); chk("simul_nostart", o_st, 0);
        clr(); step(); chk("flush_2nd", o_fl, 1);
        step(); chk("flush_done", o_fl, 0);

        // mul/div handshake, done after 6 wait cycles
        clr(); mul = 1; step(); chk("md_start", o_st, 1);
        clr(); npc = 0; nex = 0;
        for (int i = 0; i < 6; i++) begin step(); npc += o_pc; nex += o_ex; end
        chk("md_pc_len", npc, 6); chk("md_ex_len", nex, 6);
        done = 1; step(); chk("md_done_pc", o_pc, 0); chk("md_done_ex", o_ex, 0);
        clr(); step(); chk("md_no_err", o_err, 0); chk("md_start_once", o_st, 0);

        // done coincident with timeout: done wins
        mul = 1; step(); clr();
        for (int i = 0; i < MDTO - 1; i++) step();
        done = 1; step(); chk("to_done_pc", o_pc, 0);
        clr(); step(); chk("to_done_noerr", o_err, 0);

        // timeout
        mul = 1; step(); clr(); npc = 0;
        for (int i = 0; i < MDTO; i++) begin step(); npc += o_pc; end
        chk("to_len", npc, MDTO);
        step(); chk("to_pc_drop", o_pc, 0); chk("to_err", o_err, 1);
        step(); step(); chk("to_err_sticky", o_err, 1);

        // reset mid-wait
        mul = 1; step(); clr();
        for (int i = 0; i < 3; i++) step();
        rst_n = 0; #1;
        chk("rstmd_pc", hz.pcStall, 0); chk("rstmd_ex", hz.exStall, 0);
        chk("rstmd_sc", hz.stallCycles, 0); chk("rstmd_err", hz.mdError, 0);
        #1; rst_n = 1; model_reset();
        step(); chk("rstmd_nostart", o_st, 0); chk("rstmd_run", o_pc, 0);

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            for (int k = 0; k < FWD; k++) rd[k] = 5'($urandom_range(0, 7));
            wr = FWD'($urandom);
            drs1 = 5'($urandom_range(0, 7)); drs2 = 5'($urandom_range(0, 7));
            use1 = 1'($urandom); use2 = 1'($urandom);
            ld = ($urandom_range(0, 2) == 0); br = ($urandom_range(0, 7) == 0);
            mul = ($urandom_range(0, 5) == 0); done = ($urandom_range(0, 4) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
